// File: rtl/plic_pkg.sv
// plic_pkg
// Shared constants and types for the PLIC target slice.
//   PLIC_NUM_SRC  : number of interrupt source slots (slot 0 is reserved, never a real source)
//   PLIC_ID_W     : width of a source or target ID
//   PLIC_PRIO_W   : width of a priority or threshold value
//   PLIC_LOCK_CYC : cycles a just-claimed ID stays masked after a claim
//   claim_state_e : claim FSM states
package plic_pkg;

  localparam int PLIC_NUM_SRC  = 32;
  localparam int PLIC_ID_W     = 5;
  localparam int PLIC_PRIO_W   = 3;
  localparam int PLIC_LOCK_CYC = 3;
  localparam int PLIC_LOCK_W   = 2;

  typedef enum logic {
    CLAIM_IDLE,
    CLAIM_LOCK
  } claim_state_e;

endpackage

// File: rtl/plic_prio_arbiter.sv
// plic_prio_arbiter
// Combinational max-priority select over all sources. Written so that any
// target context can reuse it with its own candidate mask.
//   cand     : in  - candidate mask, one bit per source (bit 0 is never selected)
//   prio     : in  - per-source priority, packed
//   id       : out - winning source ID, 0 when nothing qualifies
//   max_prio : out - priority of the winner, 0 when nothing qualifies
module plic_prio_arbiter
  import plic_pkg::*;
(
  input  logic [PLIC_NUM_SRC-1:0]                  cand,
  input  logic [PLIC_NUM_SRC-1:0][PLIC_PRIO_W-1:0] prio,
  output logic [PLIC_ID_W-1:0]                     id,
  output logic [PLIC_PRIO_W-1:0]                   max_prio
);

  // Scan upward and only replace the winner on a strictly greater priority,
  // so equal priorities resolve to the lowest ID. Starting from priority 0
  // means a zero-priority source can never win.
  always_comb begin
    id       = '0;
    max_prio = '0;
    for (int i = 1; i < PLIC_NUM_SRC; i++) begin
      if (cand[i] && (prio[i] > max_prio)) begin
        id       = PLIC_ID_W'(i);
        max_prio = prio[i];
      end
    end
  end

endmodule

// File: rtl/plic_target.sv
// plic_target
// One PLIC target (hart context): arbitrates pending+enabled sources, drives
// the external interrupt line, and runs the claim/complete handshakes.
//   clk, rst           : clock and synchronous active-high reset
//   int_pending        : in  - gateway pending flags per source (bit 0 ignored)
//   src_prio           : in  - per-source priority (entry 0 ignored)
//   enable             : in  - per-source enable for this target (bit 0 ignored)
//   threshold          : in  - target priority threshold
//   irq                : out - external interrupt to the hart
//   claim_req/claim_rdy/claim_rsp_valid/claim_rsp_id : register-side claim read
//   complete_req/complete_id                         : register-side complete write
//   claim_valid/claim_src/claim_tgt                  : claim broadcast to gateways
//   complete_valid/complete_src/complete_tgt         : complete broadcast to gateways
module plic_target
  import plic_pkg::*;
#(
  parameter int TGT_ID = 0
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [PLIC_NUM_SRC-1:0]                  int_pending,
  input  logic [PLIC_NUM_SRC-1:0][PLIC_PRIO_W-1:0] src_prio,
  input  logic [PLIC_NUM_SRC-1:0]                  enable,
  input  logic [PLIC_PRIO_W-1:0]                   threshold,
  output logic                                     irq,
  input  logic                                     claim_req,
  output logic                                     claim_rdy,
  output logic                                     claim_rsp_valid,
  output logic [PLIC_ID_W-1:0]                     claim_rsp_id,
  input  logic                                     complete_req,
  input  logic [PLIC_ID_W-1:0]                     complete_id,
  output logic                                     claim_valid,
  output logic [PLIC_ID_W-1:0]                     claim_src,
  output logic [PLIC_ID_W-1:0]                     claim_tgt,
  output logic                                     complete_valid,
  output logic [PLIC_ID_W-1:0]                     complete_src,
  output logic [PLIC_ID_W-1:0]                     complete_tgt
);

  localparam logic [PLIC_ID_W-1:0] TGT = PLIC_ID_W'(TGT_ID);

  claim_state_e             state;
  logic [PLIC_LOCK_W-1:0]   lock_cnt;
  logic [PLIC_ID_W-1:0]     lock_id;
  logic [PLIC_ID_W-1:0]     best_id;
  logic [PLIC_PRIO_W-1:0]   best_prio;
  logic [PLIC_NUM_SRC-1:0]  cand;
  logic [PLIC_ID_W-1:0]     arb_id;
  logic [PLIC_PRIO_W-1:0]   arb_prio;
  logic [PLIC_ID_W-1:0]     win_id;

  // Build the candidate mask. While locked, the ID just handed out is hidden
  // because its gateway pending flag may not have dropped yet. Slot 0 is
  // forced off since source 0 does not exist.
  always_comb begin
    cand = '0;
    for (int i = 0; i < PLIC_NUM_SRC; i++) begin
      cand[i] = int_pending[i] & enable[i] & (src_prio[i] != '0) &
                ~((state == CLAIM_LOCK) && (lock_id == PLIC_ID_W'(i)));
    end
    cand[0] = 1'b0;
  end

  plic_prio_arbiter u_arb (
    .cand     (cand),
    .prio     (src_prio),
    .id       (arb_id),
    .max_prio (arb_prio)
  );

  // A claim only returns a source that would currently raise irq; otherwise 0.
  assign win_id    = (best_prio > threshold) ? best_id : '0;
  assign claim_rdy = (state == CLAIM_IDLE);

  // Arbitration pipeline, irq, and the claim FSM. best_* is registered from
  // the arbiter and irq is registered from best_*, so a pending edge reaches
  // irq two clocks later. An accepted claim answers on the next cycle and, for
  // a real ID, broadcasts the claim and holds LOCK for PLIC_LOCK_CYC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= CLAIM_IDLE;
      lock_cnt        <= '0;
      lock_id         <= '0;
      best_id         <= '0;
      best_prio       <= '0;
      irq             <= 1'b0;
      claim_rsp_valid <= 1'b0;
      claim_rsp_id    <= '0;
      claim_valid     <= 1'b0;
      claim_src       <= '0;
      claim_tgt       <= TGT;
    end else begin
      best_id         <= arb_id;
      best_prio       <= arb_prio;
      irq             <= (best_prio > threshold);
      claim_rsp_valid <= 1'b0;
      claim_valid     <= 1'b0;
      claim_tgt       <= TGT;
      case (state)
        CLAIM_IDLE: begin
          if (claim_req) begin
            claim_rsp_valid <= 1'b1;
            claim_rsp_id    <= win_id;
            if (win_id != '0) begin
              claim_valid <= 1'b1;
              claim_src   <= win_id;
              lock_id     <= win_id;
              lock_cnt    <= PLIC_LOCK_W'(PLIC_LOCK_CYC - 1);
              state       <= CLAIM_LOCK;
            end
          end
        end
        CLAIM_LOCK: begin
          if (lock_cnt == '0) begin
            state <= CLAIM_IDLE;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: state <= CLAIM_IDLE;
      endcase
    end
  end

  // Complete path is independent of the claim FSM: any complete with a real
  // ID is forwarded to the gateways one cycle later as a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      complete_valid <= 1'b0;
      complete_src   <= '0;
      complete_tgt   <= TGT;
    end else begin
      complete_valid <= complete_req && (complete_id != '0);
      complete_tgt   <= TGT;
      if (complete_req && (complete_id != '0)) begin
        complete_src <= complete_id;
      end
    end
  end

endmodule

// File: tb/tb_plic_target.sv
// tb_plic_target
// Self-checking bench for plic_target: a table of static arbitration vectors
// (each followed by one claim) plus hand-written sequences for the lock
// window, simultaneous claim/complete, complete of ID 0 and reset mid-lock.
module tb_plic_target;
  import plic_pkg::*;

  localparam int TGT_ID = 5;

  logic                                     clk;
  logic                                     rst;
  logic [PLIC_NUM_SRC-1:0]                  int_pending;
  logic [PLIC_NUM_SRC-1:0][PLIC_PRIO_W-1:0] src_prio;
  logic [PLIC_NUM_SRC-1:0]                  enable;
  logic [PLIC_PRIO_W-1:0]                   threshold;
  logic                                     irq;
  logic                                     claim_req;
  logic                                     claim_rdy;
  logic                                     claim_rsp_valid;
  logic [PLIC_ID_W-1:0]                     claim_rsp_id;
  logic                                     complete_req;
  logic [PLIC_ID_W-1:0]                     complete_id;
  logic                                     claim_valid;
  logic [PLIC_ID_W-1:0]                     claim_src;
  logic [PLIC_ID_W-1:0]                     claim_tgt;
  logic                                     complete_valid;
  logic [PLIC_ID_W-1:0]                     complete_src;
  logic [PLIC_ID_W-1:0]                     complete_tgt;

  int checks;
  int errors;

  typedef struct {
    logic [31:0]       pending;
    logic [31:0]       en;
    logic [31:0][2:0]  prio;
    logic [2:0]        th;
    logic              exp_irq;
    logic [4:0]        exp_id;
  } vec_t;

  vec_t vecs[9];

  plic_target #(.TGT_ID(TGT_ID)) dut (
    .clk             (clk),
    .rst             (rst),
    .int_pending     (int_pending),
    .src_prio        (src_prio),
    .enable          (enable),
    .threshold       (threshold),
    .irq             (irq),
    .claim_req       (claim_req),
    .claim_rdy       (claim_rdy),
    .claim_rsp_valid (claim_rsp_valid),
    .claim_rsp_id    (claim_rsp_id),
    .complete_req    (complete_req),
    .complete_id     (complete_id),
    .claim_valid     (claim_valid),
    .claim_src       (claim_src),
    .claim_tgt       (claim_tgt),
    .complete_valid  (complete_valid),
    .complete_src    (complete_src),
    .complete_tgt    (complete_tgt)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it, so inputs driven
  // here are stable before the next edge and outputs sampled here reflect it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [31:0] pend, input logic [31:0] en,
                                 input int sa, input int pa, input int sb, input int pb,
                                 input logic [2:0] th, input logic ei, input logic [4:0] eid);
    vec_t v;
    v.pending  = pend;
    v.en       = en;
    v.prio     = '0;
    v.prio[sa] = 3'(pa);
    v.prio[sb] = 3'(pb);
    v.th       = th;
    v.exp_irq  = ei;
    v.exp_id   = eid;
    return v;
  endfunction

  task automatic do_reset();
    rst          = 1'b1;
    claim_req    = 1'b0;
    complete_req = 1'b0;
    complete_id  = '0;
    int_pending  = '0;
    enable       = '0;
    src_prio     = '0;
    threshold    = '0;
    tick();
    rst = 1'b0;
  endtask

  // Reset, load one vector's static inputs, check irq latency and value,
  // then issue a single claim and check the response and broadcast pulses.
  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    do_reset();
    int_pending = v.pending;
    enable      = v.en;
    src_prio    = v.prio;
    threshold   = v.th;
    tick();
    checkOutput($sformatf("v%0d irq_latency", idx), 32'(irq), 32'(1'b0));
    tick();
    checkOutput($sformatf("v%0d irq", idx), 32'(irq), 32'(v.exp_irq));
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput($sformatf("v%0d rsp_valid", idx), 32'(claim_rsp_valid), 32'(1'b1));
    checkOutput($sformatf("v%0d rsp_id", idx), 32'(claim_rsp_id), 32'(v.exp_id));
    checkOutput($sformatf("v%0d claim_valid", idx), 32'(claim_valid), 32'(v.exp_id != 5'd0));
    if (v.exp_id != 5'd0) begin
      checkOutput($sformatf("v%0d claim_src", idx), 32'(claim_src), 32'(v.exp_id));
      checkOutput($sformatf("v%0d claim_tgt", idx), 32'(claim_tgt), 32'(TGT_ID));
    end
    tick();
    checkOutput($sformatf("v%0d rsp_pulse_end", idx), 32'(claim_rsp_valid), 32'(1'b0));
    checkOutput($sformatf("v%0d claim_pulse_end", idx), 32'(claim_valid), 32'(1'b0));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Table of arbitration vectors: pending, enable, two (src,prio) pairs,
    // threshold, expected irq, expected claimed ID.
    vecs[0] = mkVec(32'h0000_0028, 32'h0000_0028,  3, 2,  5, 2, 3'd1, 1'b1, 5'd3);
    vecs[1] = mkVec(32'h0000_0080, 32'h0000_0080,  7, 4,  7, 4, 3'd4, 1'b0, 5'd0);
    vecs[2] = mkVec(32'h0000_0001, 32'h0000_0001,  0, 7,  0, 7, 3'd0, 1'b0, 5'd0);
    vecs[3] = mkVec(32'h8000_0004, 32'h8000_0004,  2, 3, 31, 5, 3'd0, 1'b1, 5'd31);
    vecs[4] = mkVec(32'h0000_0050, 32'h0000_0040,  4, 7,  6, 1, 3'd0, 1'b1, 5'd6);
    vecs[5] = mkVec(32'h0000_0500, 32'h0000_0500,  8, 0, 10, 1, 3'd0, 1'b1, 5'd10);
    vecs[6] = mkVec(32'h0000_0002, 32'h0000_0002,  1, 7,  1, 7, 3'd7, 1'b0, 5'd0);
    vecs[7] = mkVec(32'h0010_1000, 32'h0010_1000, 12, 6, 20, 6, 3'd5, 1'b1, 5'd12);
    vecs[8] = mkVec(32'h0000_0200, 32'h0000_0200,  9, 3,  9, 3, 3'd2, 1'b1, 5'd9);

    // Reset state
    do_reset();
    checkOutput("rst claim_rdy", 32'(claim_rdy), 32'(1'b1));
    checkOutput("rst irq", 32'(irq), 32'(1'b0));
    checkOutput("rst rsp_valid", 32'(claim_rsp_valid), 32'(1'b0));
    checkOutput("rst claim_valid", 32'(claim_valid), 32'(1'b0));
    checkOutput("rst complete_valid", 32'(complete_valid), 32'(1'b0));
    checkOutput("rst claim_tgt", 32'(claim_tgt), 32'(TGT_ID));
    checkOutput("rst complete_tgt", 32'(complete_tgt), 32'(TGT_ID));

    for (int i = 0; i < 9; i++) begin
      applyStimulus(i);
    end

    // Lock window: claim 9 with claim_req held and 9 still pending; three
    // cycles not ready, then the next claim must return 11, not 9.
    do_reset();
    int_pending = 32'h0000_0A00;
    enable      = 32'h0000_0A00;
    src_prio[9]  = 3'd5;
    src_prio[11] = 3'd3;
    tick();
    tick();
    claim_req = 1'b1;
    tick();
    checkOutput("lock first id", 32'(claim_rsp_id), 32'd9);
    checkOutput("lock first claim_valid", 32'(claim_valid), 32'(1'b1));
    checkOutput("lock rdy0 c1", 32'(claim_rdy), 32'(1'b0));
    for (int k = 2; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("lock rdy0 c%0d", k), 32'(claim_rdy), 32'(1'b0));
      checkOutput($sformatf("lock no rsp c%0d", k), 32'(claim_rsp_valid), 32'(1'b0));
      checkOutput($sformatf("lock no claim c%0d", k), 32'(claim_valid), 32'(1'b0));
    end
    tick();
    checkOutput("lock rdy back", 32'(claim_rdy), 32'(1'b1));
    checkOutput("lock no rsp c4", 32'(claim_rsp_valid), 32'(1'b0));
    tick();
    claim_req = 1'b0;
    checkOutput("lock second rsp_valid", 32'(claim_rsp_valid), 32'(1'b1));
    checkOutput("lock second id", 32'(claim_rsp_id), 32'd11);
    checkOutput("lock second claim_src", 32'(claim_src), 32'd11);

    // Simultaneous claim and complete of 9, then complete during LOCK,
    // then complete of ID 0 which must not pulse.
    do_reset();
    int_pending = 32'h0000_0200;
    enable      = 32'h0000_0200;
    src_prio[9] = 3'd2;
    tick();
    tick();
    claim_req    = 1'b1;
    complete_req = 1'b1;
    complete_id  = 5'd9;
    tick();
    claim_req    = 1'b0;
    complete_req = 1'b0;
    checkOutput("both claim_valid", 32'(claim_valid), 32'(1'b1));
    checkOutput("both claim_src", 32'(claim_src), 32'd9);
    checkOutput("both complete_valid", 32'(complete_valid), 32'(1'b1));
    checkOutput("both complete_src", 32'(complete_src), 32'd9);
    checkOutput("both complete_tgt", 32'(complete_tgt), 32'(TGT_ID));
    complete_req = 1'b1;
    complete_id  = 5'd4;
    tick();
    complete_req = 1'b0;
    checkOutput("lock complete_valid", 32'(complete_valid), 32'(1'b1));
    checkOutput("lock complete_src", 32'(complete_src), 32'd4);
    tick();
    checkOutput("complete pulse_end", 32'(complete_valid), 32'(1'b0));
    complete_req = 1'b1;
    complete_id  = 5'd0;
    tick();
    complete_req = 1'b0;
    checkOutput("complete id0", 32'(complete_valid), 32'(1'b0));

    // Reset asserted during LOCK: ready again with no pulses afterwards.
    do_reset();
    int_pending = 32'h0000_0200;
    enable      = 32'h0000_0200;
    src_prio[9] = 3'd2;
    tick();
    tick();
    claim_req = 1'b1;
    tick();
    claim_req = 1'b0;
    checkOutput("rl entered lock", 32'(claim_rdy), 32'(1'b0));
    rst          = 1'b1;
    complete_req = 1'b1;
    complete_id  = 5'd3;
    tick();
    rst          = 1'b0;
    complete_req = 1'b0;
    checkOutput("rl claim_rdy", 32'(claim_rdy), 32'(1'b1));
    checkOutput("rl claim_valid", 32'(claim_valid), 32'(1'b0));
    checkOutput("rl rsp_valid", 32'(claim_rsp_valid), 32'(1'b0));
    checkOutput("rl complete_valid", 32'(complete_valid), 32'(1'b0));
    checkOutput("rl irq", 32'(irq), 32'(1'b0));

    // Reset on the same edge as a would-be claim: no response follows.
    rst       = 1'b1;
    claim_req = 1'b1;
    tick();
    rst       = 1'b0;
    claim_req = 1'b0;
    checkOutput("rc rsp_valid", 32'(claim_rsp_valid), 32'(1'b0));
    checkOutput("rc claim_valid", 32'(claim_valid), 32'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/plic_target.md
PLIC_TARGET -- requirements
Module: plic_target

Interface
REQ-001 The module SHALL have parameter TGT_ID, default 0, meaning the 5-bit target (hart context) index this instance serves.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The module SHALL have port int_pending, input, 32, per-source gateway pending flags; bit 0 is ignored (source 0 does not exist).
REQ-005 The module SHALL have port src_prio, input, 32x3 packed, per-source priority; entry 0 is ignored.
REQ-006 The module SHALL have port enable, input, 32, per-source enable bits for this target; bit 0 is ignored.
REQ-007 The module SHALL have port threshold, input, 3, the target priority threshold.
REQ-008 The module SHALL have port irq, output, 1, the external interrupt line to the hart.
REQ-009 The module SHALL have ports claim_req (input, 1), claim_rdy (output, 1), claim_rsp_valid (output, 1) and claim_rsp_id (output, 5), forming the register-side claim read handshake.
REQ-010 The module SHALL have ports complete_req (input, 1) and complete_id (input, 5), forming the register-side complete write.
REQ-011 The module SHALL have ports claim_valid, claim_src and claim_tgt (outputs, 1/5/5), forming the claim broadcast to all gateways.
REQ-012 The module SHALL have ports complete_valid, complete_src and complete_tgt (outputs, 1/5/5), forming the complete broadcast to all gateways.

Function
REQ-013 A source i (1..31) SHALL be a candidate when int_pending[i] & enable[i] & src_prio[i] != 0, and it is not masked by REQ-019.
REQ-014 Each cycle, the block SHALL register best_id/best_prio, the highest-priority candidate; ties go to the lowest ID; with no candidate, best_id=0 and best_prio=0.
REQ-015 irq SHALL be registered to (best_prio > threshold), giving two cycles of latency from an int_pending edge to irq; the compare is unsigned 3-bit.
REQ-016 The claim FSM SHALL have states IDLE and LOCK; claim_rdy=1 only in IDLE.
REQ-017 When claim_req & claim_rdy, the block SHALL respond next cycle with claim_rsp_valid=1 for one cycle:
  - claim_rsp_id = best_id if best_prio > threshold, else 0.
REQ-018 On the same accepted claim, if the returned ID != 0, the block SHALL:
  - pulse claim_valid for one cycle together with the response, with claim_src = ID and claim_tgt = TGT_ID;
  - enter LOCK for exactly 3 cycles, then return to IDLE.
REQ-019 During LOCK, the just-claimed ID SHALL be excluded from candidates, so stale pending status is never re-claimed.
REQ-020 A claim returning ID 0 SHALL produce no claim_valid and SHALL stay in IDLE.
REQ-021 claim_req while claim_rdy=0 SHALL be ignored, and the requester SHALL hold it.
REQ-022 When complete_req, the block SHALL pulse complete_valid one cycle later for one cycle, with complete_src = complete_id and complete_tgt = TGT_ID; complete_id == 0 SHALL produce no pulse.
REQ-023 Complete SHALL be accepted in any FSM state; a simultaneous claim and complete SHALL both be processed independently.
REQ-024 An out-of-range priority, threshold or enable change mid-LOCK SHALL take effect at the next registered arbitration, except for the REQ-019 mask.

Reset
REQ-025 rst SHALL drive the FSM to IDLE and clear best_id, best_prio, irq, claim_rsp_valid, claim_rsp_id, claim_valid, claim_src, complete_valid, complete_src and the LOCK counter to 0; claim_tgt and complete_tgt SHALL reset to TGT_ID.
REQ-026 rst asserted mid-LOCK or mid-response SHALL abort the operation with no pulse in the following cycle.

Structure
REQ-027 Package plic_pkg SHALL hold PLIC_NUM_SRC=32, PLIC_ID_W=5, PLIC_PRIO_W=3, PLIC_LOCK_CYC=3 and the claim FSM state enum.
REQ-028 The combinational max-priority select SHALL be a sub-module plic_prio_arbiter (inputs: candidate mask and priorities; outputs: id and prio), reusable by other targets.

Verification
REQ-029 Sources 3 (prio 2) and 5 (prio 2) pending and enabled, threshold 1 -> irq=1 two cycles later; claim returns 3.
REQ-030 Source 7 prio 4, threshold 4 -> irq stays 0; claim returns 0 with no claim_valid.
REQ-031 Claim of 9 followed by claim_req held every cycle -> claim_rdy low for 3 cycles; next claim returns the next candidate or 0, never 9 again.
REQ-032 complete_req with id 9 in the same cycle as an accepted claim -> next cycle shows both complete_valid (src 9) and claim_valid pulses.
REQ-033 complete_id 0 -> no complete_valid; rst asserted during LOCK -> claim_rdy=1 and all pulses 0 in the cycle after reset.
